// File: rtl/fifo_pkg.sv
// Width helpers shared by the multi-port FIFO and its storage array.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF    = 32;
  localparam int FIFO_LOGDEPTH_DEF = 3;
  localparam int FIFO_PORTS_DEF    = 2;

  // Head/tail pointers wrap naturally at 2^LOGDEPTH.
  function automatic int fifo_ptr_w(input int logdepth);
    return logdepth;
  endfunction

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int fifo_cnt_w(input int logdepth);
    return logdepth + 1;
  endfunction

  function automatic int fifo_lane_w(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  // enq_num/deq_num encode 0..PORTS.
  function automatic int fifo_num_w(input int ports);
    return $clog2(ports + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: PORTS write ports, PORTS asynchronous read ports.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH_DEF,
  parameter int LOGDEPTH = FIFO_LOGDEPTH_DEF,
  parameter int PORTS    = FIFO_PORTS_DEF
) (
  input  logic                                      clk,
  input  logic [PORTS-1:0]                          we,
  input  logic [PORTS-1:0][fifo_ptr_w(LOGDEPTH)-1:0] waddr,
  input  logic [PORTS-1:0][WIDTH-1:0]               wdata,
  input  logic [PORTS-1:0][fifo_ptr_w(LOGDEPTH)-1:0] raddr,
  output logic [PORTS-1:0][WIDTH-1:0]               rdata
);

  localparam int DEPTH = 1 << LOGDEPTH;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

  // Write lanes always target distinct slots, so lane order does not matter.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < PORTS; i++) begin
      if (we[i]) mem_d[waddr[i]] = wdata[i];
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar i = 0; i < PORTS; i++) begin : g_rd
    assign rdata[i] = mem_q[raddr[i]];
  end

endmodule

// File: rtl/multi_port_fifo.sv
// Multi-entry-per-cycle FIFO: up to PORTS pushes and pops per clock, first-word-fall-through.
module multi_port_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH_DEF,
  parameter int LOGDEPTH = FIFO_LOGDEPTH_DEF,
  parameter int PORTS    = FIFO_PORTS_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [$clog2(PORTS+1)-1:0] enq_num,
  input  logic [PORTS*WIDTH-1:0]     enq_data,
  output logic                       enq_ready,
  output logic [PORTS-1:0]           deq_valid,
  output logic [PORTS*WIDTH-1:0]     deq_data,
  input  logic [$clog2(PORTS+1)-1:0] deq_num,
  input  logic                       flush,
  output logic [LOGDEPTH:0]          count
);

  localparam int DEPTH = 1 << LOGDEPTH;
  localparam int PTR_W = fifo_ptr_w(LOGDEPTH);
  localparam int CNT_W = fifo_cnt_w(LOGDEPTH);
  localparam int NUM_W = fifo_num_w(PORTS);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] PORTS_C = CNT_W'(PORTS);
  localparam logic [NUM_W-1:0] PORTS_N = NUM_W'(PORTS);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq_ok;
  logic [CNT_W-1:0] enq_cnt, deq_cnt;

  logic [PORTS-1:0]            we;
  logic [PORTS-1:0][PTR_W-1:0] waddr, raddr;
  logic [PORTS-1:0][WIDTH-1:0] wdata, rdata;

  // Handshake outputs come only from registered occupancy.
  assign enq_ready = (DEPTH_C - count_q) >= PORTS_C;
  assign count     = count_q;

  always_comb begin
    enq_ok  = enq_ready && (enq_num != '0) && (enq_num <= PORTS_N);
    enq_cnt = enq_ok ? CNT_W'(enq_num) : '0;
    // Out-of-range deq_num is dropped; in-range requests saturate at occupancy.
    if (deq_num > PORTS_N)                deq_cnt = '0;
    else if (CNT_W'(deq_num) > count_q)   deq_cnt = count_q;
    else                                  deq_cnt = CNT_W'(deq_num);
  end

  always_comb begin
    head_d  = head_q + PTR_W'(deq_cnt);
    tail_d  = tail_q + PTR_W'(enq_cnt);
    count_d = count_q + enq_cnt - deq_cnt;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  for (genvar i = 0; i < PORTS; i++) begin : g_lane
    assign we[i]    = enq_ok && !flush && (NUM_W'(i) < enq_num);
    assign waddr[i] = tail_q + PTR_W'(i);
    assign raddr[i] = head_q + PTR_W'(i);
    assign wdata[i] = enq_data[i*WIDTH +: WIDTH];
    assign deq_data[i*WIDTH +: WIDTH] = rdata[i];
    assign deq_valid[i] = count_q > CNT_W'(i);
  end

  fifo_mem #(
    .WIDTH   (WIDTH),
    .LOGDEPTH(LOGDEPTH),
    .PORTS   (PORTS)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata)
  );

endmodule
